divider_period_meter: RTL and testbench
=======================================

Name: divider_period_meter

Overview:
Downstream monitor for clock_divider. Samples the divided clock_out as a data signal in the clock_in domain and measures its period and high time in clock_in cycles. Detects a stalled divider with a timeout. Delivers each measurement over a valid/ready handshake to a status/CSR consumer.

Parameters:
CNT_W, 28, width of the period/high counters; matches the clock_divider divisor width
TIMEOUT_CYC, 1000, number of clock_in cycles without a div_clk rising edge that declares a stall; legal range 2 to 2^CNT_W-1

Ports:
clock_in  input  1  system clock, same clock that drives clock_divider
rst  input  1  synchronous reset, active-high
enable  input  1  1 = measure; 0 = idle and clear the measurement counters
div_clk  input  1  clock_out of clock_divider, treated as data
period_data  output  CNT_W  clock_in cycles between two consecutive div_clk rising edges
high_data  output  CNT_W  clock_in cycles div_clk was high within that period
period_valid  output  1  period_data/high_data hold a measurement
period_ready  input  1  consumer accepts the measurement when valid&ready
timeout  output  1  level; divider stalled (no rising edge for TIMEOUT_CYC cycles)
overflow_err  output  1  sticky; a measurement was dropped because the output register was full

Behaviour:
- Interface: one clock, clock_in. Reset rst is synchronous and active-high.
- Reset values: period_data=0, high_data=0, period_valid=0, timeout=0, overflow_err=0. Reset also clears the synchronizer and the FSM returns to IDLE.
- Reset mid-operation: discards any pending measurement.
- Input path: 2-FF synchronizer on div_clk, then a third register for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed latency of 3 clock_in cycles, so measured intervals are exact.
  - div_clk must be high and low for at least 1 clock_in cycle each (divisor ≥ 2). Faster signals are unsupported.
- FSM states: IDLE, ARM, MEASURE, STALL.
  - IDLE: counters held at 0. enable=1 -> ARM.
  - ARM: wait for rise. On rise -> MEASURE with per_cnt=1, hi_cnt=1.
  - MEASURE, each cycle without rise: per_cnt+=1; hi_cnt+=1 while s2=1 (stops counting after fall).
  - MEASURE, on rise:
    - capture period_data=per_cnt, high_data=hi_cnt;
    - restart with per_cnt=1, hi_cnt=1; stay in MEASURE.
  - MEASURE, per_cnt reaches TIMEOUT_CYC without rise -> STALL with timeout=1.
  - STALL: counters frozen, no capture. On rise: timeout=0, per_cnt=1, hi_cnt=1 -> MEASURE. The interval spanning the stall is never reported.
  - enable=0 in any state -> IDLE next cycle. Counters clear, timeout clears, in-flight partial measurement is discarded. An already-captured output stays valid until consumed.
- Counters saturate at 2^CNT_W-1 and never wrap (unreachable when TIMEOUT_CYC is legal).
- Output handshake:
  - period_valid rises the cycle after the capturing rise.
  - period_data/high_data stay stable while valid & ~ready.
  - valid&ready with no capture in the same cycle -> valid=0 next cycle.
  - valid&ready with a capture in the same cycle -> new data loads and valid stays 1 (no bubble).
  - Capture while valid & ~ready -> new measurement dropped, output unchanged, overflow_err=1.
  - overflow_err is cleared only by rst.
- First measurement needs two rising edges after entering ARM.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with div_clk toggling -> all outputs 0. Release with enable=0 -> no valid, no timeout.
- Nominal, divisor 4: enable=1, div_clk with period 4 (2 high/2 low), ready=1 -> first valid after the 2nd edge, then every 4 cycles; period_data=4, high_data=2.
- Odd duty, divisor 5: div_clk 2 high/3 low -> period_data=5, high_data=2 on every valid.
- Backpressure: period 4, ready=0 for 12 cycles -> the first measurement is held stable and overflow_err=1 after the next capture. Set ready=1 -> the held value drains; subsequent values are 4/2 and overflow_err stays 1.
- Stall, TIMEOUT_CYC=20: stop toggling div_clk after an edge -> timeout=1 exactly 20 cycles after the last rise pulse. Resume with period 4 -> timeout=0 on the first rise; the next valid shows 4, with no stall-length value reported.
- Enable drop mid-period: deassert enable 2 cycles after a rise, reassert 5 cycles later -> no capture during the gap; the next valid arrives only after two fresh rises, with correct 4/2 values.

Source files
------------

// File: rtl/divider_period_meter.sv
// Measures period and high time of a divided clock sampled as data in the clock_in domain,
// with stall detection and a single-entry valid/ready output register.
module divider_period_meter #(
    parameter int CNT_W       = 28,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_clk,
    output logic [CNT_W-1:0] period_data,
    output logic [CNT_W-1:0] high_data,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             timeout,
    output logic             overflow_err
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic             s1_p0, s2_p1, s3_p2;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic             rise;
    logic             capture;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign rise    = s2_p1 & ~s3_p2;
    assign capture = enable && (state == MEASURE) && rise;

    // Synchronizer, edge detect and measurement FSM
    always_ff @(posedge clock_in) begin
        if (rst) begin
            s1_p0   <= 1'b0;
            s2_p1   <= 1'b0;
            s3_p2   <= 1'b0;
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            s1_p0 <= div_clk;
            s2_p1 <= s1_p0;
            s3_p2 <= s2_p1;
            if (!enable) begin
                state   <= IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
                timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                        state   <= ARM;
                    end
                    ARM: begin
                        if (rise) begin
                            per_cnt <= CNT_ONE;
                            hi_cnt  <= CNT_ONE;
                            state   <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            per_cnt <= CNT_ONE;
                            hi_cnt  <= CNT_ONE;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                            if (s2_p1)
                                hi_cnt <= sat_inc(hi_cnt);
                            // Timeout raises on the edge where per_cnt becomes TIMEOUT_CYC
                            if (per_cnt >= TO_LAST) begin
                                state   <= STALL;
                                timeout <= 1'b1;
                            end
                        end
                    end
                    STALL: begin
                        if (rise) begin
                            per_cnt <= CNT_ONE;
                            hi_cnt  <= CNT_ONE;
                            timeout <= 1'b0;
                            state   <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output register and handshake; a capture while full is dropped and flagged
    always_ff @(posedge clock_in) begin
        if (rst) begin
            period_data  <= '0;
            high_data    <= '0;
            period_valid <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (capture) begin
                if (!period_valid || period_ready) begin
                    period_data  <= per_cnt;
                    high_data    <= hi_cnt;
                    period_valid <= 1'b1;
                end else begin
                    overflow_err <= 1'b1;
                end
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_period_meter.sv
// Directed bench for divider_period_meter: reset, nominal/odd duty, backpressure, stall, enable drop.
module tb_divider_period_meter;

    localparam int CNT_W = 28;
    localparam int TO    = 20;

    logic             clock_in = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             div_clk = 1'b0;
    logic             period_ready = 1'b0;
    logic [CNT_W-1:0] period_data, high_data;
    logic             period_valid, timeout, overflow_err;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int ph    = 0;
    int hi_len = 2;
    int lo_len = 2;
    bit gen_on = 1'b0;

    divider_period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
        .clock_in     (clock_in),
        .rst          (rst),
        .enable       (enable),
        .div_clk      (div_clk),
        .period_data  (period_data),
        .high_data    (high_data),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .timeout      (timeout),
        .overflow_err (overflow_err)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick();
        @(posedge clock_in);
        #1;
        n++;
        if (gen_on) begin
            ph = (ph + 1) % (hi_len + lo_len);
            div_clk = (ph < hi_len);
        end
    endtask

    task automatic start_gen(input int hi, input int lo);
        hi_len = hi;
        lo_len = lo;
        ph = 0;
        div_clk = 1'b1;
        gen_on = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        period_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        gen_on = 1'b0;
        div_clk = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        start_gen(1, 1);
        tick(); tick(); tick();
        total++;
        if (period_valid !== 1'b0 || timeout !== 1'b0 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: valid=%b timeout=%b ovf=%b, required 0 0 0",
                     period_valid, timeout, overflow_err);
        end
        total++;
        if (period_data !== 0 || high_data !== 0) begin
            bad++;
            $display("FAIL reset_data: period=%0d high=%0d, required 0 0", period_data, high_data);
        end
        rst = 1'b0;
        period_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        total++;
        if (period_valid !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL idle_disabled: valid=%b timeout=%b, required 0 0", period_valid, timeout);
        end
        gen_on = 1'b0;
    endtask

    task automatic test_period(input int hi, input int lo, input int exp_cnt);
        int r0, k, last, exp_n;
        do_reset();
        period_ready = 1'b1;
        enable = 1'b1;
        tick(); tick(); tick();
        start_gen(hi, lo);
        r0 = n;
        k = 0;
        last = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (period_valid) begin
                total++;
                if (period_data !== CNT_W'(hi + lo) || high_data !== CNT_W'(hi)) begin
                    bad++;
                    $display("FAIL period_data_%0d_%0d: got %0d/%0d, required %0d/%0d",
                             hi, lo, period_data, high_data, hi + lo, hi);
                end
                exp_n = (k == 0) ? r0 + 3 + hi + lo : last + hi + lo;
                total++;
                if (n !== exp_n) begin
                    bad++;
                    $display("FAIL period_timing_%0d_%0d: valid at cycle %0d, required %0d",
                             hi, lo, n - r0, exp_n - r0);
                end
                last = n;
                k++;
            end
        end
        total++;
        if (k !== exp_cnt) begin
            bad++;
            $display("FAIL period_count_%0d_%0d: %0d valids, required %0d", hi, lo, k, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int r0, k;
        bit got;
        do_reset();
        period_ready = 1'b0;
        enable = 1'b1;
        tick(); tick(); tick();
        start_gen(2, 2);
        r0 = n;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (period_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got || n !== r0 + 7 || period_data !== 4 || high_data !== 2 || overflow_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: got=%b cyc=%0d data=%0d/%0d ovf=%b, required 1 7 4/2 0",
                     got, n - r0, period_data, high_data, overflow_err);
        end
        k = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (period_valid !== 1'b1 || period_data !== 4 || high_data !== 2) k++;
        end
        total++;
        if (k !== 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", k);
        end
        total++;
        if (overflow_err !== 1'b1) begin
            bad++;
            $display("FAIL bp_overflow: ovf=%b, required 1", overflow_err);
        end
        period_ready = 1'b1;
        tick();
        total++;
        if (period_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: valid=%b, required 0", period_valid);
        end
        k = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (period_valid) begin
                k++;
                total++;
                if (period_data !== 4 || high_data !== 2) begin
                    bad++;
                    $display("FAIL bp_after: data=%0d/%0d, required 4/2", period_data, high_data);
                end
            end
        end
        total++;
        if (k !== 5 || overflow_err !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume: valids=%0d ovf=%b, required 5 1", k, overflow_err);
        end
        // Reset while holding a measurement must discard it
        period_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (period_valid) break;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (period_valid !== 1'b0 || overflow_err !== 1'b0 || period_data !== 0) begin
            bad++;
            $display("FAIL bp_reset: valid=%b ovf=%b data=%0d, required 0 0 0",
                     period_valid, overflow_err, period_data);
        end
    endtask

    task automatic test_stall();
        int m, q, k, j;
        bit got;
        do_reset();
        period_ready = 1'b1;
        enable = 1'b1;
        tick(); tick(); tick();
        start_gen(2, 2);
        k = 0;
        for (int i = 0; i < 30 && k < 2; i++) begin
            tick();
            if (period_valid) k++;
        end
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ph == 0) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if (!got || k < 2) begin
            bad++;
            $display("FAIL stall_setup: edge=%b valids=%0d, required 1 2", got, k);
        end
        m = n;
        tick();
        gen_on = 1'b0;
        tick();
        div_clk = 1'b0;
        k = 0;
        while (n < m + 21) begin
            tick();
            if (n >= m + 4 && period_valid) k++;
        end
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL stall_early: timeout=%b at 19 cycles after rise, required 0", timeout);
        end
        tick();
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("FAIL stall_assert: timeout=%b at 20 cycles after rise, required 1", timeout);
        end
        j = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (period_valid) k++;
            if (!timeout) j++;
        end
        total++;
        if (k !== 0 || j !== 0) begin
            bad++;
            $display("FAIL stall_quiet: valids=%0d timeout_drops=%0d, required 0 0", k, j);
        end
        start_gen(2, 2);
        q = n;
        tick(); tick();
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: timeout=%b before resume rise, required 1", timeout);
        end
        tick();
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL stall_clear: timeout=%b after resume rise, required 0", timeout);
        end
        k = 0;
        while (n < q + 6) begin
            tick();
            if (period_valid) k++;
        end
        tick();
        total++;
        if (k !== 0 || period_valid !== 1'b1 || period_data !== 4 || high_data !== 2) begin
            bad++;
            $display("FAIL stall_resume: early=%0d valid=%b data=%0d/%0d, required 0 1 4/2",
                     k, period_valid, period_data, high_data);
        end
    endtask

    task automatic test_enable_drop();
        int m, k;
        bit got;
        do_reset();
        period_ready = 1'b1;
        enable = 1'b1;
        tick(); tick(); tick();
        start_gen(2, 2);
        k = 0;
        for (int i = 0; i < 30 && k < 2; i++) begin
            tick();
            if (period_valid) k++;
        end
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ph == 0) begin
                got = 1'b1;
                break;
            end
        end
        m = n;
        k = 0;
        while (n < m + 4) tick();
        enable = 1'b0;
        while (n < m + 9) begin
            tick();
            if (period_valid) k++;
        end
        enable = 1'b1;
        while (n < m + 14) begin
            tick();
            if (period_valid) k++;
        end
        total++;
        if (!got || k !== 0) begin
            bad++;
            $display("FAIL en_gap: edge=%b valids_in_gap=%0d, required 1 0", got, k);
        end
        tick();
        total++;
        if (period_valid !== 1'b1 || period_data !== 4 || high_data !== 2 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL en_resume: valid=%b data=%0d/%0d timeout=%b, required 1 4/2 0",
                     period_valid, period_data, high_data, timeout);
        end
    endtask

    initial begin
        test_reset();
        test_period(2, 2, 9);
        test_period(2, 3, 7);
        test_backpressure();
        test_stall();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
